// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the architectural PC, issues one fetch per
// instruction over a valid/ready request channel, captures the returned word
// in a holding register and offers it to the core with valid/ready.
// A redirect from the core replaces the PC and kills any fetch in flight.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     fetch request channel (addr == pc)
//   imem_rsp_valid/data           fetch response strobe and word
//   inst_valid/ready, inst,       held instruction toward the core
//   inst_pc
//   redirect_valid, redirect_pc   non-sequential next PC (low 2 bits dropped)
//   pc                            current fetch PC
module ysyx_24100005_ifu #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              drop;
  logic              drop_next;
  logic              pc_we;
  logic [ADDR_W-1:0] pc_next;
  logic              capture;
  logic [ADDR_W-1:0] redirect_aligned;

  // Redirect targets are forced to word alignment.
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign imem_req_addr    = pc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        // A response that is stale (drop) or collides with a redirect is
        // discarded and a fresh fetch is started from the new PC.
        if (imem_rsp_valid) begin
          state_next = (drop || redirect_valid) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output and datapath-control logic
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    pc_we          = 1'b0;
    pc_next        = pc;
    capture        = 1'b0;
    drop_next      = drop;
    unique case (state)
      S_IDLE: ;
      S_REQ: begin
        imem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
        end
        if (imem_rsp_valid) begin
          drop_next = 1'b0;
          capture   = !drop && !redirect_valid;
        end else if (redirect_valid) begin
          // Only one fetch is outstanding, so a single flag covers any
          // number of back-to-back redirects before the response.
          drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        inst_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
        end else if (inst_ready) begin
          pc_we   = 1'b1;
          pc_next = pc + ADDR_W'(4);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= drop_next;
      if (pc_we) pc <= pc_next;
      if (capture) begin
        inst    <= imem_rsp_data;
        inst_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;

  ysyx_24100005_ifu #(
    .ADDR_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_req[$];

  int          n_cmp = 0;
  int          n_err = 0;

  // memory model state
  int          mem_delay;
  int          mem_cnt;
  logic        mem_pend;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_avail(input string tag, input int sz);
    n_cmp++;
    assert (sz != 0) else begin
      n_err++;
      $error("FAIL %s: observed=empty expected=pending entry", tag);
    end
  endtask

  // Negedge sampling: scoreboard pops on request acceptance and consumption.
  task automatic monitor();
    exp_t e;
    logic [31:0] a;
    if (imem_req_valid && imem_req_ready) begin
      chk_avail("req_unexpected", exp_req.size());
      if (exp_req.size() != 0) begin
        a = exp_req.pop_front();
        chk("req_addr", imem_req_addr, a);
      end
      mem_pend = 1'b1;
      mem_cnt  = mem_delay;
      mem_addr = imem_req_addr;
    end
    if (inst_valid && inst_ready) begin
      chk_avail("inst_unexpected", exp_q.size());
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.addr);
        chk("inst_word", inst, e.word);
      end
    end
  endtask

  task automatic mem_update();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic peek();
    #2;
  endtask

  task automatic run_until_empty(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cycle();
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: observed=%0d left expected=0 left", exp_q.size());
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.word = mem_word(a);
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_delay      = 1;
    mem_cnt        = 0;
    mem_pend       = 1'b0;
    mem_addr       = '0;

    cycle();
    cycle();
    peek();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // first fetch after reset release: IDLE, REQ, WAIT, HOLD
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    mem_delay      = 1;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    push_exp(32'h8000_0000);
    chk("idle_req_valid", imem_req_valid, 1'b0);
    cycle();
    peek();
    chk("c1_req_valid", imem_req_valid, 1'b1);
    chk("c1_req_addr", imem_req_addr, 32'h8000_0000);
    cycle();
    peek();
    chk("c2_inst_valid", inst_valid, 1'b0);
    cycle();
    peek();
    chk("c3_inst_valid", inst_valid, 1'b1);
    cycle();
    peek();
    chk("c4_pc", pc, 32'h8000_0004);

    // second word stalled 4 cycles by the core
    push_exp(32'h8000_0004);
    cycle();
    inst_ready = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      peek();
      chk("stall_inst_valid", inst_valid, 1'b1);
      chk("stall_inst_pc", inst_pc, 32'h8000_0004);
      chk("stall_inst", inst, mem_word(32'h8000_0004));
      chk("stall_req_valid", imem_req_valid, 1'b0);
      chk("stall_pc", pc, 32'h8000_0004);
      cycle();
    end
    inst_ready = 1'b1;
    peek();
    chk("unstall_inst_valid", inst_valid, 1'b1);
    cycle();
    exp_req.push_back(32'h8000_0008);
    exp_req.push_back(32'h8000_000C);
    push_exp(32'h8000_0008);
    push_exp(32'h8000_000C);
    run_until_empty(20);
    imem_req_ready = 1'b0;

    // redirect while waiting on a slow response
    exp_req.push_back(32'h8000_0010);
    exp_req.push_back(32'h8000_0100);
    imem_req_ready = 1'b1;
    mem_delay      = 3;
    cycle();
    mem_delay      = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    peek();
    chk("wait_redir_inst_valid", inst_valid, 1'b0);
    cycle();
    redirect_valid = 1'b0;
    peek();
    chk("wait_redir_pc", pc, 32'h8000_0100);
    cycle();
    peek();
    chk("stale_rsp_inst_valid", imem_rsp_valid & ~inst_valid, 1'b1);
    cycle();
    push_exp(32'h8000_0100);
    run_until_empty(20);
    imem_req_ready = 1'b0;

    // redirect in the same cycle as the response
    exp_req.push_back(32'h8000_0104);
    exp_req.push_back(32'h8000_0300);
    imem_req_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    peek();
    chk("collide_rsp_valid", imem_rsp_valid, 1'b1);
    chk("collide_inst_valid", inst_valid, 1'b0);
    cycle();
    redirect_valid = 1'b0;
    peek();
    chk("collide_inst_valid_after", inst_valid, 1'b0);
    chk("collide_pc", pc, 32'h8000_0300);
    push_exp(32'h8000_0300);
    run_until_empty(20);
    imem_req_ready = 1'b0;

    // redirect during HOLD with an unaligned target
    exp_req.push_back(32'h8000_0304);
    exp_req.push_back(32'h8000_0200);
    imem_req_ready = 1'b1;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    peek();
    chk("hold_redir_inst_valid", inst_valid, 1'b0);
    chk("hold_redir_req_valid", imem_req_valid, 1'b0);
    cycle();
    redirect_valid = 1'b0;
    peek();
    chk("hold_redir_pc", pc, 32'h8000_0200);
    push_exp(32'h8000_0200);
    run_until_empty(20);
    imem_req_ready = 1'b0;

    // redirect in REQ to the top word, then wrap to zero
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    peek();
    chk("req_redir_req_valid", imem_req_valid, 1'b0);
    cycle();
    redirect_valid = 1'b0;
    peek();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    push_exp(32'hFFFF_FFFC);
    run_until_empty(20);
    peek();
    chk("wrap_pc", pc, 32'h0000_0000);
    mem_delay = 3;
    cycle();

    // reset mid-WAIT; the late response must be ignored
    rst = 1'b0;
    peek();
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_inst_valid", inst_valid, 1'b0);
    chk("midrst_req_valid", imem_req_valid, 1'b0);
    cycle();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    cycle();
    peek();
    chk("late_rsp_seen", imem_rsp_valid, 1'b1);
    chk("late_rsp_inst_valid", inst_valid, 1'b0);
    chk("late_rsp_req_valid", imem_req_valid, 1'b1);
    cycle();
    peek();
    chk("post_rst_inst_valid", inst_valid, 1'b0);
    chk("post_rst_pc", pc, RESET_PC);
    cycle();
    peek();
    chk("post_rst_inst_valid2", inst_valid, 1'b0);

    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("inst_queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
